fsk_symbol_scheduler: RTL and testbench
=======================================

# fsk_symbol_scheduler

Sequencer that sits in front of the 16/8/4/2-FSK modulator/demodulator top level and drives its `start` and `data_in` inputs. It buffers upstream symbols in a small FIFO, issues the modem start pulse, and emits a fixed-length preamble. It then presents one payload symbol per symbol period, masked to the selected M-ary mode. This replaces hand-timed stimulus with a reusable frame controller used in both the transmit chain and the BER benches.

## Interface
- `SYMBOL_CYCLES`, 100: clocks per symbol (1000 ns at 100 MHz); must be ≥ 2.
- `START_CYCLES`, 2: width of the modem start pulse, in clocks.
- `PREAMBLE_LEN`, 4: preamble symbols per frame; 0 means no preamble.
- `FIFO_DEPTH`, 8: symbol FIFO entries; must be a power of 2.
- `clk` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: permits a new frame to start from IDLE.
- `abort` in 1: synchronous; ends the current frame and flushes the FIFO.
- `mode` in 2: 0=2FSK, 1=4FSK, 2=8FSK, 3=16FSK; sampled at frame start.
- `in_valid` in 1: upstream symbol valid.
- `in_ready` out 1: high when the FIFO is not full.
- `in_data` in 4: upstream symbol.
- `in_last` in 1: marks the final symbol of the frame.
- `mod_start` out 1: goes to the modem `start` input.
- `mod_data` out 4: goes to the modem `data_in` input.
- `sym_strobe` out 1: one-cycle pulse on the cycle `mod_data` takes a new symbol.
- `busy` out 1: high from START until the frame ends.
- `underrun` out 1: sticky; cleared by reset or at the next frame start.

## Operation
- FIFO entry is {last, data[3:0]}. A push happens when `in_valid && in_ready`.
- States:
  - IDLE: `mod_data`=0.
  - START: `mod_start`=1 for START_CYCLES clocks, `mod_data`=0.
  - PREAMBLE: PREAMBLE_LEN symbols, alternating 0, M−1, 0, … starting with 0.
  - PAYLOAD: one FIFO symbol per period.
- IDLE→START when `enable` is high and the FIFO is not empty. At this transition `mode` is latched into `mode_q` and `underrun` is cleared.
- START→PREAMBLE after START_CYCLES clocks, or →PAYLOAD if PREAMBLE_LEN=0.
- M = 2^(mode_q+1). Payload symbol = `data & (M−1)`, so upper bits are zeroed in modes below 16FSK.
- Symbol boundary in PAYLOAD:
  - FIFO not empty: pop the entry and drive the masked symbol.
  - FIFO empty: hold the previous symbol and set `underrun`.
- After the period of a symbol whose `last`=1 completes, go to IDLE. `mod_data`=0 and `busy`=0 on that same edge.
- `abort` in any state: next edge goes to IDLE, `mod_data`=0, `mod_start`=0, FIFO emptied. `abort` overrides a simultaneous push.
- Dropping `enable` mid-frame has no effect; the frame completes.
- Changing `mode` mid-frame has no effect.

## Timing
- Reset values: `mod_data`=0, `mod_start`=0, `sym_strobe`=0, `busy`=0, `underrun`=0. After reset, `in_ready`=1 (FIFO empty).
- All outputs are registered except `in_ready`, which is decoded from the registered FIFO count.
- Frame start latency: `enable` and FIFO not empty at edge N → `mod_start`=1 and `busy`=1 from edge N+1.
- First preamble symbol appears, with `sym_strobe`, at edge N+1+START_CYCLES. Each later symbol follows exactly SYMBOL_CYCLES clocks after the previous one.
- Symbol counter runs 0..SYMBOL_CYCLES−1 and wraps to 0 at each boundary.
- FIFO full: `in_ready`=0, and a pop in the same cycle does not admit a push.
- FIFO empty: a push and a boundary pop in the same cycle count as an underrun; there is no bypass path. The pushed symbol is used at the next boundary.
- Pointer wrap: log2(FIFO_DEPTH)-bit pointers plus a count of log2(FIFO_DEPTH)+1 bits.

## Structure
- `fsk_pkg`: mode encoding constants, state enum {IDLE, START, PREAMBLE, PAYLOAD}, and a function `mode_mask(mode)` returning M−1.
- Sub-module `fsk_sym_fifo`: synchronous FIFO, 5 bits wide, FIFO_DEPTH entries, with ports push/pop/full/empty/flush.
- Top level contains the FSM, the symbol counter, the preamble counter and the output registers.

## Test plan
- Reset with `reset_n`=0 mid-PAYLOAD → all outputs 0 immediately; `in_ready`=1 after release.
- `mode`=3, push 0x1, 0xE, 0xB(last), `enable`=1 → `mod_start` high for 2 clocks, then sequence 0, F, 0, F, 1, E, B with strobes 100 clocks apart, then `mod_data`=0 and `busy`=0.
- `mode`=0, push 0x7, 0x6(last) → preamble 0, 1, 0, 1, then payload 1, 0.
- Push only 0x3 (no last) → after the 0x3 period, `mod_data` stays 3 and `underrun`=1. Then push 0x5(last) → 5 is sent, then IDLE; `underrun` stays 1 until the next frame starts.
- Fill 8 entries → `in_ready`=0; a 9th `in_valid` is not accepted; a pop re-raises `in_ready` on the following cycle.
- `abort` during PREAMBLE with 4 symbols queued → IDLE next edge, FIFO empty, `mod_data`=0, no `sym_strobe`.

Source files
------------

// File: rtl/fsk_symbol_scheduler_pkg.sv
// Shared types and helpers for the FSK symbol scheduler.
package fsk_pkg;

  localparam logic [1:0] MODE_2FSK  = 2'd0;
  localparam logic [1:0] MODE_4FSK  = 2'd1;
  localparam logic [1:0] MODE_8FSK  = 2'd2;
  localparam logic [1:0] MODE_16FSK = 2'd3;

  typedef enum logic [1:0] {IDLE, START, PREAMBLE, PAYLOAD} state_e;

  typedef struct packed {
    logic       last;
    logic [3:0] data;
  } fifo_entry_t;

  // Highest symbol index (M-1) for an M-ary mode.
  function automatic logic [3:0] mode_mask(input logic [1:0] mode);
    case (mode)
      MODE_2FSK: return 4'h1;
      MODE_4FSK: return 4'h3;
      MODE_8FSK: return 4'h7;
      default:   return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/fsk_sym_fifo.sv
// Symbol FIFO: {last,data} entries, power-of-2 depth, flush overrides push/pop.
module fsk_sym_fifo
  import fsk_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  fifo_entry_t din_i,
  output fifo_entry_t dout_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  fifo_entry_t   mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fsk_symbol_scheduler.sv
// Frame sequencer for the FSK modem: start pulse, alternating preamble,
// then one masked FIFO symbol per symbol period.
module fsk_symbol_scheduler
  import fsk_pkg::*;
#(
  parameter int SYMBOL_CYCLES = 100,
  parameter int START_CYCLES  = 2,
  parameter int PREAMBLE_LEN  = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       abort,
  input  logic [1:0] mode,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       in_last,
  output logic       mod_start,
  output logic [3:0] mod_data,
  output logic       sym_strobe,
  output logic       busy,
  output logic       underrun
);

  localparam int CMAX = (SYMBOL_CYCLES > START_CYCLES) ? SYMBOL_CYCLES : START_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = $clog2(PREAMBLE_LEN + 2);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    mode_q, mode_d;
  logic [3:0]    data_q, data_d;
  logic          start_q, start_d, strobe_q, strobe_d, busy_q, busy_d;
  logic          unr_q, unr_d, last_q, last_d;

  fifo_entry_t   fifo_din, fifo_dout;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic          start_done, sym_wrap, pre_done, bnd, pay_step, pre_step, end_step;

  assign fifo_din  = '{last: in_last, data: in_data};
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full && !abort;

  fsk_sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (abort),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // One shared counter times both the start pulse and the symbol period.
  assign start_done = (cnt_q == CW'(START_CYCLES - 1));
  assign sym_wrap   = (cnt_q == CW'(SYMBOL_CYCLES - 1));
  assign pre_done   = (pre_q == PW'(PREAMBLE_LEN));
  assign bnd        = ((state_q == START) && start_done) ||
                      (((state_q == PREAMBLE) || (state_q == PAYLOAD)) && sym_wrap);
  assign pay_step   = bnd && ((state_q == PAYLOAD) ||
                              ((state_q == PREAMBLE) && pre_done) ||
                              ((state_q == START) && (PREAMBLE_LEN == 0)));
  assign pre_step   = bnd && !pay_step;
  assign end_step   = (state_q == PAYLOAD) && sym_wrap && last_q;
  assign fifo_pop   = pay_step && !end_step && !fifo_empty && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pre_q    <= '0;
      mode_q   <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      unr_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      start_q  <= start_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      unr_q    <= unr_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (enable && !fifo_empty) state_d = START;
        START:    if (start_done) state_d = (PREAMBLE_LEN == 0) ? PAYLOAD : PREAMBLE;
        PREAMBLE: if (sym_wrap && pre_done) state_d = PAYLOAD;
        PAYLOAD:  if (end_step) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    mode_d   = mode_q;
    data_d   = data_q;
    unr_d    = unr_q;
    last_d   = last_q;
    strobe_d = 1'b0;
    start_d  = (state_d == START);
    busy_d   = (state_d != IDLE);
    if (state_q == IDLE) begin
      if (state_d == START) begin
        mode_d = mode;
        unr_d  = 1'b0;
        last_d = 1'b0;
        cnt_d  = '0;
        pre_d  = '0;
      end
    end else begin
      cnt_d = bnd ? '0 : cnt_q + CW'(1);
      if (pre_step) begin
        data_d   = pre_q[0] ? mode_mask(mode_q) : 4'h0;
        strobe_d = 1'b1;
        pre_d    = pre_q + PW'(1);
      end else if (pay_step && !end_step && !abort) begin
        // An empty FIFO at a boundary holds the previous symbol.
        if (!fifo_empty) begin
          data_d   = fifo_dout.data & mode_mask(mode_q);
          last_d   = fifo_dout.last;
          strobe_d = 1'b1;
        end else begin
          unr_d = 1'b1;
        end
      end
    end
    if (state_d == IDLE) begin
      data_d   = 4'h0;
      strobe_d = 1'b0;
    end
  end

  assign mod_start  = start_q;
  assign mod_data   = data_q;
  assign sym_strobe = strobe_q;
  assign busy       = busy_q;
  assign underrun   = unr_q;

endmodule

// File: tb/tb_fsk_symbol_scheduler.sv
// Scoreboard bench: stimulus queues expected symbols, a negedge monitor checks each strobe.
module tb_fsk_symbol_scheduler;

  localparam int SC  = 100;
  localparam int STC = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0, abort = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] in_data = 4'h0;
  logic       in_ready, mod_start, sym_strobe, busy, underrun;
  logic [3:0] mod_data;

  fsk_symbol_scheduler #(
    .SYMBOL_CYCLES(SC), .START_CYCLES(STC), .PREAMBLE_LEN(4), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .abort(abort), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mod_start(mod_start), .mod_data(mod_data), .sym_strobe(sym_strobe),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    int         gap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, ref_cyc = 0, last_strobe_cyc = 0;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // gap is measured from busy rising (first symbol) or from the previous strobe
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy && !busy_prev) ref_cyc = cyc;
      if (sym_strobe) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_strobe: got symbol %0h, nothing expected (cycle %0d)", mod_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("sym_data", {28'h0, mod_data}, mon_e.d);
          if (mon_e.gap != 0) check("sym_gap", cyc - ref_cyc, mon_e.gap);
        end
        ref_cyc = cyc;
        last_strobe_cyc = cyc;
      end
    end
    busy_prev = busy;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_sym(input logic [3:0] d, input int gap);
    exp_t e;
    e.d = d;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic push_sym(input logic [3:0] d, input logic l);
    check("in_ready_before_push", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic start_frame();
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    check("start_mod_start", mod_start, 1);
    check("start_busy", busy, 1);
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int k = 0;
    while (busy && k < maxc) begin
      step(1);
      k++;
    end
    check(name, busy, 0);
    check("idle_mod_data", {28'h0, mod_data}, 0);
  endtask

  task automatic expect_preamble(input logic [3:0] m);
    expect_sym(4'h0, STC);
    expect_sym(m, SC);
    expect_sym(4'h0, SC);
    expect_sym(m, SC);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    // reset values
    step(3);
    check("rst_mod_data", {28'h0, mod_data}, 0);
    check("rst_mod_start", mod_start, 0);
    check("rst_strobe", sym_strobe, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    reset_n = 1'b1;
    step(1);
    check("rst_in_ready", in_ready, 1);

    // 16FSK frame; mode change mid-frame is ignored
    mode = 2'd3;
    push_sym(4'h1, 1'b0);
    push_sym(4'hE, 1'b0);
    push_sym(4'hB, 1'b1);
    expect_preamble(4'hF);
    expect_sym(4'h1, SC);
    expect_sym(4'hE, SC);
    expect_sym(4'hB, SC);
    start_frame();
    check("start_mod_data", {28'h0, mod_data}, 0);
    mode = 2'd0;
    step(1);
    check("start_pulse_2nd", mod_start, 1);
    step(1);
    check("start_pulse_end", mod_start, 0);
    check("first_pre_strobe", sym_strobe, 1);
    wait_idle(1000, "f16_timeout");
    check("f16_end_gap", cyc - last_strobe_cyc, SC);
    step(3);

    // 2FSK frame: upper bits masked
    mode = 2'd0;
    push_sym(4'h7, 1'b0);
    push_sym(4'h6, 1'b1);
    expect_preamble(4'h1);
    expect_sym(4'h1, SC);
    expect_sym(4'h0, SC);
    start_frame();
    wait_idle(1000, "f2_timeout");
    step(3);

    // underrun: hold 3, then late 5(last)
    mode = 2'd3;
    push_sym(4'h3, 1'b0);
    expect_preamble(4'hF);
    expect_sym(4'h3, SC);
    start_frame();
    k = 0;
    while (!underrun && k < 1000) begin
      step(1);
      k++;
    end
    check("unr_set", underrun, 1);
    check("unr_hold_data", {28'h0, mod_data}, 4'h3);
    check("unr_when", cyc - last_strobe_cyc, SC);
    check("unr_busy", busy, 1);
    expect_sym(4'h5, 2 * SC);
    push_sym(4'h5, 1'b1);
    wait_idle(1000, "unr_timeout");
    check("unr_sticky", underrun, 1);
    step(3);

    // full FIFO, rejected 9th, in_ready re-raised by a pop
    mode = 2'd1;
    push_sym(4'hA, 1'b0);
    push_sym(4'hB, 1'b0);
    push_sym(4'hC, 1'b0);
    push_sym(4'hD, 1'b0);
    push_sym(4'hE, 1'b0);
    push_sym(4'hF, 1'b0);
    push_sym(4'h1, 1'b0);
    push_sym(4'h2, 1'b1);
    check("full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 4'h9;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("full_hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    expect_preamble(4'h3);
    expect_sym(4'h2, SC);
    expect_sym(4'h3, SC);
    expect_sym(4'h0, SC);
    expect_sym(4'h1, SC);
    expect_sym(4'h2, SC);
    expect_sym(4'h3, SC);
    expect_sym(4'h1, SC);
    expect_sym(4'h2, SC);
    start_frame();
    check("unr_cleared", underrun, 0);
    k = 0;
    while (!in_ready && k < 1000) begin
      step(1);
      k++;
    end
    check("pop_in_ready", in_ready, 1);
    check("pop_strobe", sym_strobe, 1);
    check("pop_data", {28'h0, mod_data}, 4'h2);
    wait_idle(1500, "full_timeout");
    enable = 1'b1;
    step(2);
    check("no_9th_entry", busy, 0);
    enable = 1'b0;
    step(2);

    // abort during preamble, with a simultaneous push
    mode = 2'd3;
    push_sym(4'h1, 1'b0);
    push_sym(4'h2, 1'b0);
    push_sym(4'h3, 1'b0);
    push_sym(4'h4, 1'b1);
    expect_sym(4'h0, STC);
    expect_sym(4'hF, SC);
    start_frame();
    step(130);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h7;
    step(1);
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_mod_data", {28'h0, mod_data}, 0);
    check("abort_mod_start", mod_start, 0);
    check("abort_strobe", sym_strobe, 0);
    check("abort_in_ready", in_ready, 1);
    step(150);
    enable = 1'b1;
    step(2);
    check("abort_fifo_empty", busy, 0);
    enable = 1'b0;
    check("abort_sb_drained", sb.size(), 0);
    step(2);

    // async reset mid-payload
    push_sym(4'h9, 1'b0);
    push_sym(4'h6, 1'b1);
    expect_preamble(4'hF);
    expect_sym(4'h9, SC);
    expect_sym(4'h6, SC);
    start_frame();
    step(450);
    check("pay_busy", busy, 1);
    check("pay_data", {28'h0, mod_data}, 4'h9);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_mod_data", {28'h0, mod_data}, 0);
    check("arst_busy", busy, 0);
    check("arst_mod_start", mod_start, 0);
    check("arst_strobe", sym_strobe, 0);
    check("arst_underrun", underrun, 0);
    sb.delete();
    step(2);
    reset_n = 1'b1;
    step(1);
    check("arst_in_ready", in_ready, 1);
    step(5);
    check("final_busy", busy, 0);
    check("final_sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
